// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle of the hazard unit: datapath register indices and controls in,
// stall/flush/forward selects back out.
interface hazard_unit_if;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE;
  logic       DmemReqM, DmemReadyM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, DmemReqM, DmemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, DmemReqM, DmemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: forwarding, load-use stall, branch flush and a
// data-memory wait FSM with timeout. Define HAZARD_PERF_EN to build the performance counters.
module hazard_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_if.slave     hz,
  output logic             BusErr,
  output logic [CNT_W-1:0] LuStallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);
  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        bus_err_q, bus_err_d;
  logic        lw, mw, memstall;

  assign lw = hz.ResultSrcE_zero & (hz.RdE != 5'd0) & ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
  assign mw = hz.DmemReqM & ~hz.DmemReadyM;

  always_comb begin
    memstall = 1'b0;
    case (state_q)
      IDLE:    memstall = mw;
      WAIT:    memstall = ~hz.DmemReadyM;
      ERR:     memstall = 1'b1;
      default: memstall = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        if (mw) begin
          state_d = WAIT;
          timer_d = 16'd1;
        end
      end
      WAIT: begin
        if (hz.DmemReadyM) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_V) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign BusErr = bus_err_q;

  // Memory stall freezes the whole front end; a pending branch stays in E until released.
  always_comb begin
    hz.StallF = lw;
    hz.StallD = lw;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = hz.PCSrcE;
    hz.FlushE = lw | hz.PCSrcE;
    hz.FlushW = 1'b0;
    if (memstall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b1;
    end
  end

  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E) hz.ForwardAE = 2'b01;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E) hz.ForwardBE = 2'b01;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;

  always_comb begin
    lu_cnt_d = lu_cnt_q + CNT_W'(lw & ~memstall);
    fl_cnt_d = fl_cnt_q + CNT_W'(hz.PCSrcE & ~memstall);
    mw_cnt_d = mw_cnt_q + CNT_W'(memstall & (state_q != ERR));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      mw_cnt_q <= mw_cnt_d;
    end
  end

  assign LuStallCnt = lu_cnt_q;
  assign FlushCnt   = fl_cnt_q;
  assign MemWaitCnt = mw_cnt_q;
`else
  assign LuStallCnt = '0;
  assign FlushCnt   = '0;
  assign MemWaitCnt = '0;
`endif

endmodule
